mem_port_arbiter: RTL and testbench

- Shares one memory port between instruction fetch (requester IF) and the load/store unit (requester LS).
- Sequences each access: grant on acceptance, then for reads wait for the response and route read data back to the owner.
- LS has fixed priority; a starvation counter forces an IF grant after a bounded run of LS grants.
- A watchdog terminates read responses that never arrive; sticky error flag for debug.

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares a single memory port between instruction fetch (IF) and the
//   load/store unit (LS). LS has fixed priority, but a starvation counter
//   forces an IF grant after STARVE_MAX consecutive LS grants while IF waits.
//   Reads are sequenced: grant, wait for the response, and route the data
//   back to the owner as a registered 1-cycle rvalid pulse. A watchdog ends
//   reads whose response never arrives; o_err is a sticky debug flag.
//
// Handshake: a requester raises i_x_req with stable fields and holds them
//   until o_x_gnt. The grant is combinational and equals "this requester won
//   arbitration in IDLE" AND i_mem_ready, i.e. the cycle the memory accepts
//   the request. Read data returns as o_x_rvalid (one cycle) with o_x_rdata,
//   which then holds until that requester's next response.
//
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_if_* / o_if_*                 IF read request, grant, response
//   i_ls_* / o_ls_*                 LS load/store request, grant, response
//   o_mem_* / i_mem_*               shared memory port
//   o_err                           sticky error (timeout or stray response)
//   o_dbg_state                     current FSM state (0 IDLE, 1 WAIT_RD)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_ls_req,
  input  logic                i_ls_we,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_bmask,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic                i_mem_ready,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_err,
  output logic [0:0]          o_dbg_state
);

  localparam int BM_W = DATA_W / 8;
  localparam int SC_W = 4;
  localparam int WD_W = 10;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_WAIT_RD = 1'b1;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              owner_q, owner_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              err_q, err_d;

  logic idle;
  logic ls_win, if_win;
  logic if_gnt, ls_gnt;
  logic starved;
  logic timeout_hit;

  // Arbitration and memory-port drive (combinational).
  always_comb begin
    idle    = (state_q == S_IDLE);
    starved = i_if_req && (starve_cnt_q == SC_W'(STARVE_MAX));
    ls_win  = idle && i_ls_req && !starved;
    if_win  = idle && i_if_req && !ls_win;
    if_gnt  = if_win && i_mem_ready;
    ls_gnt  = ls_win && i_mem_ready;

    o_mem_req   = ls_win || if_win;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = '0;
    if (ls_win) begin
      o_mem_we    = i_ls_we;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
      o_mem_bmask = i_ls_bmask;
    end else if (if_win) begin
      // Fetches are always full-word reads.
      o_mem_addr  = i_if_addr;
      o_mem_bmask = {BM_W{1'b1}};
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    owner_d      = owner_q;
    if_rvalid_d  = 1'b0;
    ls_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    err_d        = err_q;
    timeout_hit  = (wd_cnt_q == WD_W'(TIMEOUT - 1));

    case (state_q)
      S_IDLE: begin
        // No read is outstanding, so any response here is stray (late after
        // a timeout, or from a read cut short by reset).
        if (i_mem_rvalid) err_d = 1'b1;
        if (if_gnt) begin
          owner_d  = OWN_IF;
          wd_cnt_d = '0;
          state_d  = S_WAIT_RD;
        end else if (ls_gnt && !i_ls_we) begin
          owner_d  = OWN_LS;
          wd_cnt_d = '0;
          state_d  = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        // A real response beats the watchdog in the same cycle.
        if (i_mem_rvalid || timeout_hit) begin
          if (!i_mem_rvalid) err_d = 1'b1;
          if (owner_q == OWN_LS) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = i_mem_rvalid ? i_mem_rdata : '0;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = i_mem_rvalid ? i_mem_rdata : '0;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counts LS grants that IF had to watch go by.
    if (!i_if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (ls_gnt && (starve_cnt_q < SC_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= '0;
      wd_cnt_q     <= '0;
      owner_q      <= OWN_IF;
      if_rvalid_q  <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      owner_q      <= owner_d;
      if_rvalid_q  <= if_rvalid_d;
      ls_rvalid_q  <= ls_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
      err_q        <= err_d;
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_ls_gnt    = ls_gnt;
  assign o_if_rvalid = if_rvalid_q;
  assign o_ls_rvalid = ls_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (STARVE_MAX=4, TIMEOUT=8).
//   Inputs change on the falling edge; outputs are checked 1 ns later, so
//   combinational outputs reflect the current cycle and registered outputs
//   reflect the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BM_W   = DATA_W / 8;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req, ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [BM_W-1:0]   ls_bmask;
  logic              ls_gnt, ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BM_W-1:0]   mem_bmask;
  logic              mem_ready, mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              err;
  logic [0:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: read data expected back at the next response pulse.
  logic [DATA_W-1:0] exp_q[$];

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4), .TIMEOUT(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
    .i_ls_wdata(ls_wdata), .i_ls_bmask(ls_bmask),
    .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
    .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_err(err), .o_dbg_state(dbg_state)
  );

  // Clock / global time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL time_limit: simulation still running at %0t, required done", $time);
    $fatal(1, "time limit");
  end

  // Checking task.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_if(input logic req, input logic [ADDR_W-1:0] addr);
    if_req  = req;
    if_addr = addr;
  endtask

  task automatic drive_ls(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [BM_W-1:0] bmask);
    ls_req   = req;
    ls_we    = we;
    ls_addr  = addr;
    ls_wdata = wdata;
    ls_bmask = bmask;
  endtask

  task automatic drive_mem(input logic ready, input logic rvalid, input logic [DATA_W-1:0] rdata);
    mem_ready  = ready;
    mem_rvalid = rvalid;
    mem_rdata  = rdata;
  endtask

  task automatic idle_inputs();
    drive_if(1'b0, '0);
    drive_ls(1'b0, 1'b0, '0, '0, '0);
    drive_mem(1'b0, 1'b0, '0);
  endtask

  // Pops the scoreboard and checks the rdata that came with a pulse.
  task automatic expect_resp(input string tag, input logic [DATA_W-1:0] obs);
    logic [DATA_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected nothing queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick(); settle();

    // ---- Reset state ----
    check("rst_state", dbg_state, 0);
    check("rst_err", err, 0);
    check("rst_if_rvalid", if_rvalid, 0);
    check("rst_ls_rvalid", ls_rvalid, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_ls_rdata", ls_rdata, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    tick(); rst_n = 1'b1;
    tick();

    // ---- IF only read ----
    drive_if(1'b1, 32'h100);
    drive_mem(1'b1, 1'b0, '0);
    settle();
    check("if_gnt_c0", if_gnt, 1);
    check("if_ls_gnt_c0", ls_gnt, 0);
    check("if_mem_req", mem_req, 1);
    check("if_mem_addr", mem_addr, 32'h100);
    check("if_mem_we", mem_we, 0);
    check("if_mem_bmask", mem_bmask, 4'hF);
    check("if_mem_wdata", mem_wdata, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      drive_if(1'b0, '0);
      if (i == 3) begin
        drive_mem(1'b1, 1'b1, 32'h0050_0093);
        exp_q.push_back(32'h0050_0093);
      end
      settle();
      check("if_wait_state", dbg_state, 1);
      check("if_wait_mem_req", mem_req, 0);
      check("if_wait_rvalid", if_rvalid, 0);
    end
    tick(); drive_mem(1'b1, 1'b0, '0); settle();
    check("if_rvalid_pulse", if_rvalid, 1);
    expect_resp("if_rdata", if_rdata);
    check("if_ls_rvalid", ls_rvalid, 0);
    check("if_back_idle", dbg_state, 0);
    tick(); settle();
    check("if_rvalid_1cyc", if_rvalid, 0);
    check("if_rdata_hold", if_rdata, 32'h0050_0093);

    // ---- Starvation: both requesting, LS stores ----
    tick();
    drive_if(1'b1, 32'h200);
    drive_ls(1'b1, 1'b1, 32'h1000, 32'h1111_2222, 4'hF);
    drive_mem(1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("starve_ls_gnt%0d", k), ls_gnt, 1);
      check($sformatf("starve_if_wait%0d", k), if_gnt, 0);
      check($sformatf("starve_mem_we%0d", k), mem_we, 1);
      tick();
    end
    settle();
    check("starve_if_gnt", if_gnt, 1);
    check("starve_ls_blocked", ls_gnt, 0);
    check("starve_if_addr", mem_addr, 32'h200);
    tick();
    drive_if(1'b0, '0);
    drive_mem(1'b1, 1'b1, 32'hCAFE_0001);
    exp_q.push_back(32'hCAFE_0001);
    settle();
    check("starve_wait_no_gnt", ls_gnt, 0);
    tick();
    drive_mem(1'b1, 1'b0, '0);
    settle();
    check("starve_if_rvalid", if_rvalid, 1);
    expect_resp("starve_if_rdata", if_rdata);
    check("starve_ls_resume", ls_gnt, 1);
    tick();
    drive_ls(1'b0, 1'b0, '0, '0, '0);

    // ---- LS store with memory back-pressure ----
    drive_ls(1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011);
    drive_mem(1'b0, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) mem_ready = 1'b1;
      settle();
      check($sformatf("st_req%0d", c), mem_req, 1);
      check($sformatf("st_addr%0d", c), mem_addr, 32'h2000);
      check($sformatf("st_wdata%0d", c), mem_wdata, 32'hDEAD_BEEF);
      check($sformatf("st_bmask%0d", c), mem_bmask, 4'b0011);
      check($sformatf("st_we%0d", c), mem_we, 1);
      check($sformatf("st_gnt%0d", c), ls_gnt, (c == 2) ? 1 : 0);
      tick();
    end
    drive_ls(1'b0, 1'b0, '0, '0, '0);
    settle();
    check("st_stay_idle", dbg_state, 0);
    check("st_no_rvalid", ls_rvalid, 0);
    check("st_mem_idle", mem_req, 0);

    // ---- Response and timeout in the same cycle ----
    tick();
    drive_ls(1'b1, 1'b0, 32'h3000, '0, 4'hF);
    drive_mem(1'b1, 1'b0, '0);
    settle();
    check("race_gnt", ls_gnt, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      drive_ls(1'b0, 1'b0, '0, '0, '0);
      if (i == 8) begin
        drive_mem(1'b1, 1'b1, 32'h1234_5678);
        exp_q.push_back(32'h1234_5678);
      end
      settle();
      check("race_wait", dbg_state, 1);
    end
    tick(); drive_mem(1'b1, 1'b0, '0); settle();
    check("race_rvalid", ls_rvalid, 1);
    expect_resp("race_rdata", ls_rdata);
    check("race_no_err", err, 0);

    // ---- Timeout ----
    tick();
    drive_ls(1'b1, 1'b0, 32'h3004, '0, 4'hF);
    settle();
    check("to_gnt", ls_gnt, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      drive_ls(1'b0, 1'b0, '0, '0, '0);
      settle();
      check($sformatf("to_wait%0d", i), dbg_state, 1);
      check($sformatf("to_no_rvalid%0d", i), ls_rvalid, 0);
      check($sformatf("to_no_err%0d", i), err, 0);
    end
    tick(); settle();
    check("to_rvalid", ls_rvalid, 1);
    check("to_rdata_zero", ls_rdata, 0);
    check("to_err", err, 1);
    check("to_idle", dbg_state, 0);
    // Next request proceeds normally; error stays set.
    drive_ls(1'b1, 1'b0, 32'h3008, '0, 4'hF);
    settle();
    check("to_next_gnt", ls_gnt, 1);
    tick();
    drive_ls(1'b0, 1'b0, '0, '0, '0);
    drive_mem(1'b1, 1'b1, 32'h5A5A_5A5A);
    exp_q.push_back(32'h5A5A_5A5A);
    tick(); drive_mem(1'b1, 1'b0, '0); settle();
    check("to_next_rvalid", ls_rvalid, 1);
    expect_resp("to_next_rdata", ls_rdata);
    check("to_err_sticky", err, 1);

    // ---- Reset in the middle of a read ----
    tick();
    drive_ls(1'b1, 1'b0, 32'h4000, '0, 4'hF);
    settle();
    check("rmr_gnt", ls_gnt, 1);
    tick();
    drive_ls(1'b0, 1'b0, '0, '0, '0);
    settle();
    check("rmr_wait", dbg_state, 1);
    rst_n = 1'b0;
    settle();
    check("rmr_state", dbg_state, 0);
    check("rmr_err", err, 0);
    check("rmr_ls_rdata", ls_rdata, 0);
    check("rmr_if_rdata", if_rdata, 0);
    check("rmr_ls_rvalid", ls_rvalid, 0);
    tick();
    rst_n = 1'b1;
    drive_mem(1'b1, 1'b1, 32'h7777_7777);
    settle();
    check("rmr_stray_no_gnt", ls_gnt, 0);
    tick();
    drive_mem(1'b1, 1'b0, '0);
    settle();
    check("rmr_stray_err", err, 1);
    check("rmr_stray_no_rvalid", ls_rvalid, 0);
    check("rmr_stray_rdata", ls_rdata, 0);
    check("rmr_idle", dbg_state, 0);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
